set_unit_pipe: RTL and testbench



---
 rtl/set_unit_pipe.sv | 120 ++++++++++++
 tb/tb_set_unit_pipe.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/set_unit_pipe.sv
// rtl/set_unit_pipe.sv - two-stage set-condition unit returning cond and Z/N/V/C of a - b
// Optional feature: define SET_UNSIGNED_EN to support SLTU/SGEU; otherwise they return 0 and flag illegal.
module set_unit_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             illegal
);
    localparam logic [2:0] OP_SEQ  = 3'b000;
    localparam logic [2:0] OP_SNE  = 3'b001;
    localparam logic [2:0] OP_SLT  = 3'b010;
    localparam logic [2:0] OP_SGT  = 3'b011;
    localparam logic [2:0] OP_SLE  = 3'b100;
    localparam logic [2:0] OP_SGE  = 3'b101;
    localparam logic [2:0] OP_SLTU = 3'b110;
    localparam logic [2:0] OP_SGEU = 3'b111;

    logic [WIDTH:0] diff;
    logic           z_c;
    logic           n_c;
    logic           v_c;
    logic           c_c;

    logic           s1_valid;
    logic           s1_z;
    logic           s1_n;
    logic           s1_v;
    logic           s1_c;
    logic [2:0]     s1_op;

    logic           s2_adv;
    logic           s1_adv;
    logic           accept;
    logic           cond;
    logic           ill;
    logic           lt;

    // Two's-complement subtract; the carry-out is the inverse of the unsigned borrow.
    assign diff = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    assign z_c  = (diff[WIDTH-1:0] == '0);
    assign n_c  = diff[WIDTH-1];
    assign v_c  = (a[WIDTH-1] != b[WIDTH-1]) & (n_c != a[WIDTH-1]);
    assign c_c  = ~diff[WIDTH];

    assign s2_adv   = ~out_valid | out_ready;
    assign s1_adv   = s1_valid & s2_adv;
    assign in_ready = ~s1_valid | s2_adv;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_z     <= 1'b0;
            s1_n     <= 1'b0;
            s1_v     <= 1'b0;
            s1_c     <= 1'b0;
            s1_op    <= 3'b000;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_z     <= z_c;
            s1_n     <= n_c;
            s1_v     <= v_c;
            s1_c     <= c_c;
            s1_op    <= op;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Signed ordering uses N^V so overflowing subtractions still compare correctly.
    always_comb begin
        cond = 1'b0;
        ill  = 1'b0;
        lt   = s1_n ^ s1_v;
        case (s1_op)
            OP_SEQ: cond = s1_z;
            OP_SNE: cond = ~s1_z;
            OP_SLT: cond = lt;
            OP_SGT: cond = ~s1_z & ~lt;
            OP_SLE: cond = s1_z | lt;
            OP_SGE: cond = ~lt;
`ifdef SET_UNSIGNED_EN
            OP_SLTU: cond = s1_c;
            OP_SGEU: cond = ~s1_c;
`else
            OP_SLTU, OP_SGEU: begin
                cond = 1'b0;
                ill  = 1'b1;
            end
`endif
            default: cond = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= 4'b0000;
            illegal   <= 1'b0;
        end else if (s1_adv) begin
            out_valid <= 1'b1;
            result    <= {{(WIDTH-1){1'b0}}, cond};
            flags     <= {s1_z, s1_n, s1_v, s1_c};
            illegal   <= ill;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_set_unit_pipe.sv
// tb/tb_set_unit_pipe.sv - randomized self-checking bench for set_unit_pipe against a behavioural model
module tb_set_unit_pipe;
    typedef struct packed {
        logic        ill;
        logic [3:0]  fl;
        logic [31:0] res;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  flags;
    logic        illegal;

    int n_cmp = 0;
    int n_bad = 0;
    int n_out = 0;
    beat_t exp_q[$];
    logic  got[$];

    logic        held_v = 1'b0;
    logic [31:0] held_res;
    logic [3:0]  held_fl;
    logic        held_ill;

    set_unit_pipe #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: ordering from true integer comparisons, V from whether the wrapped difference is exact.
    function automatic beat_t model(input logic [31:0] x, input logic [31:0] y, input logic [2:0] o);
        beat_t       r;
        longint      sx;
        longint      sy;
        logic [31:0] d;
        logic        eq;
        logic        lt;
        logic        ltu;
        logic        cond;
        sx   = longint'($signed(x));
        sy   = longint'($signed(y));
        d    = x - y;
        eq   = (x == y);
        lt   = (sx < sy);
        ltu  = (x < y);
        r.fl = {eq, d[31], ((sx - sy) != longint'($signed(d))), ltu};
        r.ill = 1'b0;
        cond = 1'b0;
        case (o)
            3'd0: cond = eq;
            3'd1: cond = !eq;
            3'd2: cond = lt;
            3'd3: cond = !lt && !eq;
            3'd4: cond = lt || eq;
            3'd5: cond = !lt;
            default: begin
`ifdef SET_UNSIGNED_EN
                cond = (o == 3'd6) ? ltu : !ltu;
`else
                cond  = 1'b0;
                r.ill = 1'b1;
`endif
            end
        endcase
        r.res = {31'b0, cond};
        return r;
    endfunction

    function automatic logic [31:0] rnd_operand();
        logic [31:0] s;
        s = 32'($urandom_range(0, 3));
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return 32'h8000_0000 | s;
            2: return s;
            default: return 32'hFFFF_FFFF - s;
        endcase
    endfunction

    always @(negedge clk) begin
        beat_t e;
        if (!rst_n) begin
            exp_q.delete();
            held_v = 1'b0;
        end else begin
            chk("in_ready_capacity", in_ready, (exp_q.size() < 2) || out_ready);
            if (held_v) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_result", result, held_res);
                chk("stall_flags", flags, held_fl);
                chk("stall_illegal", illegal, held_ill);
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_beat: got result %0h expected no beat", result);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", result, e.res);
                    chk("flags", flags, e.fl);
                    chk("illegal", illegal, e.ill);
                    got.push_back(result[0]);
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, op));
            held_v   = out_valid && !out_ready;
            held_res = result;
            held_fl  = flags;
            held_ill = illegal;
        end
    end

    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [2:0] o);
        logic done;
        done = 1'b0;
        a = x; b = y; op = o; in_valid = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        chk("send_accept", done, 1);
        in_valid = 1'b0;
    endtask

    task automatic one_shot(input string name, input logic [31:0] x, input logic [31:0] y,
                            input logic [2:0] o, input logic r, input logic [3:0] f, input logic il);
        a = x; b = y; op = o; in_valid = 1'b1;
        @(negedge clk);
        chk({name, "_in_ready"}, in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk({name, "_not_early"}, out_valid, 0);
        @(posedge clk);
        #1;
        chk({name, "_valid"}, out_valid, 1);
        chk({name, "_result"}, result, {31'b0, r});
        chk({name, "_flags"}, flags, f);
        chk({name, "_illegal"}, illegal, il);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        beat_t       m;
        int          n0;
        logic        uns_en;
        logic [31:0] x;
        logic [31:0] y;
`ifdef SET_UNSIGNED_EN
        uns_en = 1'b1;
`else
        uns_en = 1'b0;
`endif
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", flags, 0);
        chk("rst_illegal", illegal, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);

        m = model(32'h8000_0000, 32'h1, 3'd2);
        chk("pin_slt_res", m.res, 1);
        chk("pin_slt_flags", m.fl, 4'b0010);
        m = model(32'h1, 32'hFFFF_FFFF, 3'd6);
        chk("pin_sltu_flags", m.fl, 4'b0001);
        chk("pin_sltu_res", m.res, {31'b0, uns_en});
        chk("pin_sltu_ill", m.ill, !uns_en);

        @(posedge clk);
        #1;
        out_ready = 1'b1;
        one_shot("slt_ovf", 32'h8000_0000, 32'h1, 3'd2, 1'b1, 4'b0010, 1'b0);
        one_shot("seq", 32'h1234, 32'h1234, 3'd0, 1'b1, 4'b1000, 1'b0);
        one_shot("sne", 32'h1234, 32'h1234, 3'd1, 1'b0, 4'b1000, 1'b0);
        one_shot("sgt_eq", 32'd5, 32'd5, 3'd3, 1'b0, 4'b1000, 1'b0);
        one_shot("sge_eq", 32'd5, 32'd5, 3'd5, 1'b1, 4'b1000, 1'b0);
        one_shot("sltu", 32'h1, 32'hFFFF_FFFF, 3'd6, uns_en, 4'b0001, !uns_en);
        one_shot("sgeu", 32'h1, 32'hFFFF_FFFF, 3'd7, 1'b0, 4'b0001, !uns_en);

        out_ready = 1'b0;
        got.delete();
        send(32'd0, 32'd1, 3'd4);
        send(32'd1, 32'd1, 3'd4);
        a = 32'd2; b = 32'd1; op = 3'd4; in_valid = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_low", in_ready, 0);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(32'd2, 32'd1, 3'd4);
        send(32'd3, 32'd1, 3'd4);
        repeat (4) @(posedge clk);
        #1;
        chk("bp_count", got.size(), 4);
        if (got.size() == 4) begin
            chk("bp_r0", got[0], 1);
            chk("bp_r1", got[1], 1);
            chk("bp_r2", got[2], 0);
            chk("bp_r3", got[3], 0);
        end

        out_ready = 1'b0;
        send(32'h77, 32'h77, 3'd0);
        send(32'h55, 32'h55, 3'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_flags", flags, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("mid_rst_in_ready", in_ready, 1);
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        n0 = n_out;
        for (int i = 0; i < 100; i++) begin
            x = rnd_operand();
            y = ($urandom_range(0, 3) == 0) ? x : rnd_operand();
            a = x; b = y; op = 3'($urandom); in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("stream_count", n_out - n0, 100);

        for (int i = 0; i < 400; i++) begin
            x = rnd_operand();
            y = ($urandom_range(0, 3) == 0) ? x : rnd_operand();
            a = x; b = y; op = 3'($urandom);
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("drain_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
